// File: rtl/tx_block_serializer_if.sv
// -----------------------------------------------------------------------------
// tx_block_serializer_if
//   Bundles the block-write side, the UART handshake and the status flags of
//   tx_block_serializer.
//
//   master : block producer / UART side (drives writes, byte order, abort,
//            UART busy; observes bytes and status)
//   slave  : the serializer itself
//
//   blk_wr_en, blk_data, lsb_first      block push and its byte order
//   abort                               drop the block currently in flight
//   tx_active                           UART transmitter busy
//   tx_byte_out, tx_drive               byte and one-cycle start pulse to UART
//   blk_full, blk_almost_full,
//   blk_count, overflow                 FIFO status
//   busy, blk_done                      serializer status
// -----------------------------------------------------------------------------
interface tx_block_serializer_if #(
    parameter int BLOCK_BYTES = 16,
    parameter int FIFO_DEPTH  = 4
);
    logic                               blk_wr_en;
    logic [8*BLOCK_BYTES-1:0]           blk_data;
    logic                               lsb_first;
    logic                               abort;
    logic                               tx_active;
    logic [7:0]                         tx_byte_out;
    logic                               tx_drive;
    logic                               blk_full;
    logic                               blk_almost_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    blk_count;
    logic                               overflow;
    logic                               busy;
    logic                               blk_done;

    modport master (
        output blk_wr_en, blk_data, lsb_first, abort, tx_active,
        input  tx_byte_out, tx_drive, blk_full, blk_almost_full, blk_count,
               overflow, busy, blk_done
    );

    modport slave (
        input  blk_wr_en, blk_data, lsb_first, abort, tx_active,
        output tx_byte_out, tx_drive, blk_full, blk_almost_full, blk_count,
               overflow, busy, blk_done
    );
endinterface

// File: rtl/tx_block_serializer.sv
// -----------------------------------------------------------------------------
// tx_block_serializer
//   Queues whole ciphertext blocks (BLOCK_BYTES bytes each) in a FIFO of
//   FIFO_DEPTH entries and hands them byte by byte to a UART transmitter
//   using a WAIT/SEND/GAP handshake against tx_active.
//
//   Parameters : BLOCK_BYTES (>=2), FIFO_DEPTH (power of two, >=2),
//                AF_LEVEL (blk_almost_full threshold, 1..FIFO_DEPTH)
//   Ports      : clk    single clock, rising edge
//                reset  synchronous, active-high; clears FIFO, FSM, outputs
//                bus    tx_block_serializer_if.slave (writes, UART, status)
//   Option     : define TX_SER_CHECKSUM_EN to append an XOR checksum byte
//                of all data bytes after each block; blk_done then pulses
//                on the checksum byte.
// -----------------------------------------------------------------------------
module tx_block_serializer #(
    parameter int BLOCK_BYTES = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int AF_LEVEL    = FIFO_DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        reset,
    tx_block_serializer_if.slave        bus
);
    localparam int DW = 8 * BLOCK_BYTES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(BLOCK_BYTES + 1);
`ifdef TX_SER_CHECKSUM_EN
    localparam int NUM_BYTES = BLOCK_BYTES + 1;
`else
    localparam int NUM_BYTES = BLOCK_BYTES;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SEND,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;

    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic [DW-1:0]      head_reg;
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               overflow_reg;
    logic [DW-1:0]      shift_reg;
    logic [IW-1:0]      idx_reg;
`ifdef TX_SER_CHECKSUM_EN
    logic [7:0]         csum_reg;
`endif

    logic               full;
    logic               push;
    logic               pop;
    logic               last_byte;
    logic               tx_drive_c;
    logic               blk_done_c;
    logic [DW-1:0]      head_ordered;

    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign push      = bus.blk_wr_en && !full;
    assign last_byte = (idx_reg == IW'(NUM_BYTES - 1));

    // The byte order is resolved once, at LOAD: the block is rearranged so
    // that byte 0 sits in the low byte of the shift register. Later changes
    // on lsb_first therefore cannot affect a block in flight.
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_order
        assign head_ordered[8*gi +: 8] = bus.lsb_first
                                       ? head_reg[8*gi +: 8]
                                       : head_reg[8*(BLOCK_BYTES-1-gi) +: 8];
    end

    // Block storage with a registered read of the head entry. The head slot
    // is always written at least one edge before LOAD can use it, because
    // LOAD is entered only from IDLE after blk_count was seen non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.blk_data;
        end
        head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            shift_reg    <= '0;
            idx_reg      <= '0;
`ifdef TX_SER_CHECKSUM_EN
            csum_reg     <= 8'h00;
`endif
        end else begin
            state_reg <= state_next;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A write against a full FIFO is lost even if a pop frees a
            // slot at the same edge.
            if (bus.blk_wr_en && full) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                S_LOAD: begin
                    shift_reg <= head_ordered;
                    idx_reg   <= '0;
`ifdef TX_SER_CHECKSUM_EN
                    csum_reg  <= 8'h00;
`endif
                end
                S_SEND: begin
                    shift_reg <= {8'h00, shift_reg[DW-1:8]};
                    idx_reg   <= (last_byte || bus.abort) ? '0 : idx_reg + 1'b1;
`ifdef TX_SER_CHECKSUM_EN
                    csum_reg  <= csum_reg ^ shift_reg[7:0];
                    // After the last data byte, the checksum (including that
                    // byte) becomes the next byte presented to the UART.
                    if (idx_reg == IW'(BLOCK_BYTES - 1)) begin
                        shift_reg <= {{(DW-8){1'b0}}, csum_reg ^ shift_reg[7:0]};
                    end
`endif
                end
                S_WAIT, S_GAP: begin
                    if (bus.abort) begin
                        idx_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        tx_drive_c = 1'b0;
        blk_done_c = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                pop        = 1'b1;
                state_next = bus.abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (!bus.tx_active) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                // The start pulse still goes out on an aborted SEND; only
                // the completion pulse is suppressed.
                tx_drive_c = 1'b1;
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (last_byte) begin
                    blk_done_c = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                state_next = bus.abort ? S_IDLE : S_WAIT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.tx_byte_out     = shift_reg[7:0];
    assign bus.tx_drive        = tx_drive_c;
    assign bus.blk_done        = blk_done_c;
    assign bus.busy            = (state_reg != S_IDLE);
    assign bus.blk_full        = full;
    assign bus.blk_almost_full = (count_reg >= CW'(AF_LEVEL));
    assign bus.blk_count       = count_reg;
    assign bus.overflow        = overflow_reg;
endmodule

// File: tb/tb_tx_block_serializer.sv
`timescale 1ns/1ps
module tb_tx_block_serializer;
    localparam int BB = 16;
    localparam int FD = 4;
    localparam int AF = FD - 1;
    localparam int DW = 8 * BB;
`ifdef TX_SER_CHECKSUM_EN
    localparam int NB = BB + 1;
`else
    localparam int NB = BB;
`endif
    localparam bit CK = (NB != BB);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_block_serializer_if #(.BLOCK_BYTES(BB), .FIFO_DEPTH(FD)) bus ();

    tx_block_serializer #(
        .BLOCK_BYTES (BB),
        .FIFO_DEPTH  (FD),
        .AF_LEVEL    (AF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [7:0] b; logic done; int c; } rx_t;
    typedef struct { logic [7:0] b; logic done; } ex_t;

    rx_t  rx_q[$];
    ex_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic act_at_edge = 1'b0;
    int   last_c   = -100;
    logic last_done = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        act_at_edge <= bus.tx_active;
    end

    // Byte collector plus handshake rules that must hold for every pulse.
    always @(negedge clk) begin : mon
        rx_t r;
        if (bus.tx_drive === 1'b1) begin
            r.b    = bus.tx_byte_out;
            r.done = bus.blk_done;
            r.c    = cyc;
            rx_q.push_back(r);
            check("drive_while_uart_busy", act_at_edge, 1'b0);
            check("drive_spacing", (cyc - last_c) >= (last_done ? 4 : 3), 1);
            last_c    = cyc;
            last_done = bus.blk_done;
        end
        if (bus.blk_done === 1'b1) begin
            check("done_needs_drive", bus.tx_drive, 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_block();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom();
        return d;
    endfunction

    // Reference: byte k of a block under the given order.
    function automatic logic [7:0] ref_byte(input logic [DW-1:0] d, input logic lsb, input int k);
        logic [DW-1:0] t;
        t = lsb ? (d >> (8 * k)) : (d >> (8 * (BB - 1 - k)));
        return t[7:0];
    endfunction

    // nsent < 0: whole block expected; otherwise only the first nsent bytes.
    task automatic expect_blk(input logic [DW-1:0] d, input logic lsb, input int nsent);
        ex_t        x;
        logic [7:0] sum;
        int         n;
        sum = 8'h00;
        n   = (nsent < 0) ? BB : nsent;
        for (int k = 0; k < BB; k++) sum ^= ref_byte(d, lsb, k);
        for (int k = 0; k < n; k++) begin
            x.b    = ref_byte(d, lsb, k);
            x.done = (nsent < 0) && !CK && (k == BB - 1);
            exp_q.push_back(x);
        end
        if (nsent < 0 && CK) begin
            x.b    = sum;
            x.done = 1'b1;
            exp_q.push_back(x);
        end
    endtask

    task automatic push_blk(input logic [DW-1:0] d, output int e);
        bus.blk_data  = d;
        bus.blk_wr_en = 1'b1;
        tick();
        bus.blk_wr_en = 1'b0;
        e = cyc;
    endtask

    task automatic wait_bytes(input int n, input int budget, input bit rnd, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            if (rnd) bus.tx_active = ($urandom_range(0, 1) == 1);
            tick();
            t++;
        end
        if (rnd) bus.tx_active = 1'b0;
        check({tag, "_timeout"}, rx_q.size() >= n, 1);
    endtask

    task automatic compare_stream(input string tag);
        repeat (8) tick();
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check({tag, "_byte"}, rx_q[i].b, exp_q[i].b);
            check({tag, "_done"}, rx_q[i].done, exp_q[i].done);
        end
        $display("stream %s: %0d bytes received, %0d expected", tag, rx_q.size(), exp_q.size());
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int            e, s, nb;
        logic          lsb;
        logic [DW-1:0] d;
        logic [DW-1:0] blks [6];
        int            cnt_exp [5];

        cnt_exp = '{1, 2, 2, 3, 4};
        bus.blk_wr_en = 1'b0;
        bus.blk_data  = '0;
        bus.lsb_first = 1'b0;
        bus.abort     = 1'b0;
        bus.tx_active = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_count",    bus.blk_count, 0);
        check("rst_full",     bus.blk_full, 0);
        check("rst_af",       bus.blk_almost_full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_drive",    bus.tx_drive, 0);
        check("rst_done",     bus.blk_done, 0);
        check("rst_byte",     bus.tx_byte_out, 0);
        reset = 1'b0;
        tick();

        // MSB-first block 00..0F with exact timing
        for (int i = 0; i < BB; i++) d[8*(BB-1-i) +: 8] = 8'(i);
        bus.lsb_first = 1'b0;
        push_blk(d, e);
        expect_blk(d, 1'b0, -1);
        check("msb_count_after_push", bus.blk_count, 1);
        check("msb_idle_before_load", bus.busy, 0);
        tick();
        check("msb_busy_in_load", bus.busy, 1);
        tick();
        check("msb_count_popped", bus.blk_count, 0);
        wait_bytes(NB, 200, 1'b0, "msb");
        if (rx_q.size() >= NB) begin
            check("msb_first_cycle", rx_q[0].c - e, 3);
            check("msb_last_cycle",  rx_q[NB-1].c - e, 3 * NB);
        end
        compare_stream("msb");

        // Byte order latched at LOAD, toggles mid-block ignored
        bus.lsb_first = 1'b1;
        push_blk(d, e);
        expect_blk(d, 1'b1, -1);
        wait_bytes(3, 100, 1'b0, "lsb_pre");
        bus.lsb_first = 1'b0;
        wait_bytes(8, 100, 1'b0, "lsb_mid");
        bus.lsb_first = 1'b1;
        wait_bytes(11, 100, 1'b0, "lsb_mid2");
        bus.lsb_first = 1'b0;
        wait_bytes(NB, 100, 1'b0, "lsb");
        compare_stream("lsb_toggle");

        // Fill and overflow with the UART held busy
        bus.tx_active = 1'b1;
        bus.lsb_first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            blks[i] = rand_block();
            push_blk(blks[i], e);
            check("fill_count", bus.blk_count, cnt_exp[i]);
        end
        check("fill_full",     bus.blk_full, 1);
        check("fill_af",       bus.blk_almost_full, 1);
        check("fill_overflow", bus.overflow, 0);
        check("fill_busy",     bus.busy, 1);
        blks[5] = rand_block();
        push_blk(blks[5], e);
        check("ovf_set",   bus.overflow, 1);
        check("ovf_count", bus.blk_count, 4);
        repeat (10) tick();
        check("fill_held", rx_q.size(), 0);
        for (int i = 0; i < 5; i++) expect_blk(blks[i], 1'b0, -1);
        bus.tx_active = 1'b0;
        wait_bytes(5 * NB, 5 * (3 * NB + 4) + 50, 1'b0, "fill");
        compare_stream("fill");
        check("ovf_sticky", bus.overflow, 1);
        check("af_clear",   bus.blk_almost_full, 0);
        check("full_clear", bus.blk_full, 0);

        // UART backpressure after the first pulse
        d = rand_block();
        bus.lsb_first = 1'b1;
        push_blk(d, e);
        expect_blk(d, 1'b1, -1);
        wait_bytes(1, 50, 1'b0, "bp_first");
        bus.tx_active = 1'b1;
        repeat (20) tick();
        check("bp_held", rx_q.size(), 1);
        bus.tx_active = 1'b0;
        s = cyc;
        wait_bytes(2, 20, 1'b0, "bp_resume");
        if (rx_q.size() >= 2) check("bp_resume_cycle", rx_q[1].c - s, 1);
        wait_bytes(NB, 300, 1'b0, "bp");
        compare_stream("backpressure");

        // Abort in the GAP after byte 3 with two blocks queued
        bus.lsb_first = 1'b0;
        for (int i = 0; i < 3; i++) begin
            blks[i] = rand_block();
            push_blk(blks[i], e);
        end
        expect_blk(blks[0], 1'b0, 4);
        expect_blk(blks[1], 1'b0, -1);
        expect_blk(blks[2], 1'b0, -1);
        wait_bytes(4, 100, 1'b0, "abort_pre");
        s = cyc;
        check("abort_queued", bus.blk_count, 2);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle",       bus.busy, 0);
        check("abort_count_kept", bus.blk_count, 2);
        tick();
        check("abort_load_busy",  bus.busy, 1);
        tick();
        check("abort_count_pop",  bus.blk_count, 1);
        wait_bytes(4 + 2 * NB, 2 * (3 * NB + 4) + 50, 1'b0, "abort");
        if (rx_q.size() >= 5) check("abort_next_cycle", rx_q[4].c - s, 5);
        compare_stream("abort");

`ifdef TX_SER_CHECKSUM_EN
        // Checksum byte after 01..10
        for (int i = 0; i < BB; i++) d[8*(BB-1-i) +: 8] = 8'(i + 1);
        bus.lsb_first = 1'b0;
        push_blk(d, e);
        expect_blk(d, 1'b0, -1);
        wait_bytes(NB, 200, 1'b0, "csum");
        if (rx_q.size() >= NB) begin
            check("csum_byte", rx_q[NB-1].b, 8'h10);
            check("csum_done", rx_q[NB-1].done, 1'b1);
        end
        compare_stream("checksum");
`endif

        // Randomized blocks, byte order and UART busy pattern
        for (int it = 0; it < 6; it++) begin
            nb  = $urandom_range(1, 3);
            lsb = 1'($urandom_range(0, 1));
            bus.lsb_first = lsb;
            for (int j = 0; j < nb; j++) begin
                d = rand_block();
                push_blk(d, e);
                expect_blk(d, lsb, -1);
            end
            wait_bytes(nb * NB, nb * NB * 12 + 100, 1'b1, "rnd");
            compare_stream("random");
        end

        // Reset mid-block drops the block and the queue
        for (int i = 0; i < 2; i++) begin
            d = rand_block();
            push_blk(d, e);
        end
        wait_bytes(2, 100, 1'b0, "rst_mid");
        tick();
        tick();
        check("pre_rst_overflow", bus.overflow, 1);
        reset = 1'b1;
        tick();
        check("rst2_drive",    bus.tx_drive, 0);
        check("rst2_count",    bus.blk_count, 0);
        check("rst2_overflow", bus.overflow, 0);
        check("rst2_busy",     bus.busy, 0);
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        repeat (60) tick();
        check("rst2_no_drive", rx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
